pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 14 +
 rtl/pc_fetch_branch_pend.sv | 42 ++++
 rtl/pc_fetch.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package pc_fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ADEL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_branch_pend.sv
// Pending branch target: remembers a taken branch until the delay slot leaves F.
module pc_fetch_branch_pend
  import pc_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [WORD_W-1:0] target_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] target_o
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] target_q, target_d;

  // Clear wins: a redirect or an advance always consumes/discards the entry.
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (set_i) begin
      valid_d  = 1'b1;
      target_d = target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC sequencing, SRAM-like instruction request and F-stage hand-off.
// state  | meaning
// S_REQ  | presenting inst_addr (or detecting a misaligned PC)
// S_WAIT | address accepted, waiting for inst_data_ok
// S_HOLD | word buffered while D is stalled
// S_ADEL | misaligned PC reported as fetch address error until redirect
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallD,
  input  logic              exc_redirect,
  input  logic [WORD_W-1:0] exc_pc,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              is_jumpD,
  output logic              inst_req,
  output logic [WORD_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic [WORD_W-1:0] inst_rdata,
  input  logic              inst_data_ok,
  output logic [WORD_W-1:0] instrF,
  output logic [WORD_W-1:0] pcplus4F,
  output logic              adelF,
  output logic              in_delayF,
  output logic              validF
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              cancel_q, cancel_d;
  logic              delay_q, delay_d;
  logic              adv_q;

  logic              req;
  logic              valid_f;
  logic              adel_f;
  logic [WORD_W-1:0] instr_f;
  logic              advance;
  logic              pend_valid;
  logic [WORD_W-1:0] pend_target;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    buf_d    = buf_q;
    req      = 1'b0;
    valid_f  = 1'b0;
    adel_f   = 1'b0;
    instr_f  = '0;
    advance  = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (pc_q[1:0] != 2'b00) begin
          if (!exc_redirect) state_d = S_ADEL;
        end else begin
          req = 1'b1;
          if (inst_addr_ok) begin
            state_d  = S_WAIT;
            cancel_d = exc_redirect;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d  = S_REQ;
          cancel_d = 1'b0;
          if (!cancel_q) begin
            valid_f = 1'b1;
            instr_f = inst_rdata;
            advance = !exc_redirect && !stallD;
            if (!exc_redirect && stallD) begin
              state_d = S_HOLD;
              buf_d   = inst_rdata;
            end
          end
        end else if (exc_redirect) begin
          cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        valid_f = 1'b1;
        instr_f = buf_q;
        advance = !exc_redirect && !stallD;
        if (exc_redirect || !stallD) state_d = S_REQ;
      end
      S_ADEL: begin
        valid_f = 1'b1;
        adel_f  = 1'b1;
        if (exc_redirect) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // A branch resolving in the same cycle the delay slot leaves F is forwarded.
  always_comb begin
    next_pc = pc_plus4;
    if (branch_taken)    next_pc = branch_target;
    else if (pend_valid) next_pc = pend_target;
  end

  always_comb begin
    pc_d = pc_q;
    if (exc_redirect)  pc_d = exc_pc;
    else if (advance)  pc_d = next_pc;
  end

  always_comb begin
    delay_d = delay_q;
    if (exc_redirect) delay_d = 1'b0;
    else if (adv_q)   delay_d = is_jumpD;
  end

  pc_fetch_branch_pend u_branch_pend (
    .clk      (clk),
    .rst_n    (reset),
    .set_i    (branch_taken & ~exc_redirect),
    .clr_i    (exc_redirect | advance),
    .target_i (branch_target),
    .valid_o  (pend_valid),
    .target_o (pend_target)
  );

  // cancel_q starts set so a stale data_ok before the first accepted address is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      cancel_q <= 1'b1;
      delay_q  <= 1'b0;
      adv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      cancel_q <= cancel_d;
      delay_q  <= delay_d;
      adv_q    <= advance;
    end
  end

  assign inst_req  = req;
  assign inst_addr = req ? pc_q : '0;
  assign validF    = valid_f;
  assign instrF    = instr_f;
  assign adelF     = adel_f;
  assign pcplus4F  = valid_f ? pc_plus4 : '0;
  assign in_delayF = delay_q & valid_f;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed fetch sequences, monitor checks hand-offs.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallD;
  logic        exc_redirect;
  logic [31:0] exc_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        is_jumpD;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [31:0] instrF;
  logic [31:0] pcplus4F;
  logic        adelF;
  logic        in_delayF;
  logic        validF;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        adel;
    logic        dly;
  } fexp_t;

  fexp_t       data_q[$];
  logic [31:0] addr_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  fexp_t       m_e;
  logic [31:0] m_a;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stallD        (stallD),
    .exc_redirect  (exc_redirect),
    .exc_pc        (exc_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .is_jumpD      (is_jumpD),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_rdata    (inst_rdata),
    .inst_data_ok  (inst_data_ok),
    .instrF        (instrF),
    .pcplus4F      (pcplus4F),
    .adelF         (adelF),
    .in_delayF     (in_delayF),
    .validF        (validF)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expected address on each accepted request and an expected
  // F word each time the F output is consumed (validF & ~stallD).
  always @(negedge clk) begin
    if (mon_en) begin
      if (inst_req && inst_addr_ok) begin
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL addr_unexpected: got %08h expected none", inst_addr);
        end else begin
          m_a = addr_q.pop_front();
          chk("inst_addr", inst_addr, m_a);
        end
      end
      if (validF && !stallD) begin
        if (data_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL fetch_unexpected: got instr %08h expected none", instrF);
        end else begin
          m_e = data_q.pop_front();
          chk("instrF", instrF, m_e.instr);
          chk("pcplus4F", pcplus4F, m_e.pcp4);
          chk1("adelF", adelF, m_e.adel);
          chk1("in_delayF", in_delayF, m_e.dly);
        end
      end
      if (!validF) begin
        chk("bubble_instr", instrF, 32'h0);
        chk1("bubble_adel", adelF, 1'b0);
        chk1("bubble_delay", in_delayF, 1'b0);
      end
    end
  end

  // One complete fetch starting in S_REQ; jump/br are driven in the first cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] rd, input int stall,
                       input int aw, input logic jump, input logic br,
                       input logic [31:0] tgt, input logic dly);
    fexp_t e;
    e.instr = rd;
    e.pcp4  = a + 32'd4;
    e.adel  = 1'b0;
    e.dly   = dly;
    addr_q.push_back(a);
    data_q.push_back(e);
    is_jumpD      = jump;
    branch_taken  = br;
    branch_target = tgt;
    for (int i = 0; i < aw; i++) begin
      inst_addr_ok = 1'b0;
      @(negedge clk);
      chk1("addr_wait_req", inst_req, 1'b1);
      chk("addr_wait_stable", inst_addr, a);
      cyc();
      is_jumpD     = 1'b0;
      branch_taken = 1'b0;
    end
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    is_jumpD     = 1'b0;
    branch_taken = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = rd;
    stallD       = (stall > 0);
    cyc();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    for (int i = 1; i < stall; i++) begin
      @(negedge clk);
      chk1("hold_valid", validF, 1'b1);
      chk("hold_instr", instrF, rd);
      chk1("hold_noreq", inst_req, 1'b0);
      cyc();
    end
    if (stall > 0) begin
      stallD = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fexp_t e;
    reset         = 1'b0;
    stallD        = 1'b0;
    exc_redirect  = 1'b0;
    exc_pc        = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    is_jumpD      = 1'b0;
    inst_addr_ok  = 1'b0;
    inst_rdata    = 32'h1234_5678;
    inst_data_ok  = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk1("rst_req", inst_req, 1'b1);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);
    chk1("rst_valid", validF, 1'b0);
    chk("rst_instr", instrF, 32'h0);
    chk("rst_pcplus4", pcplus4F, 32'h0);
    chk1("rst_adel", adelF, 1'b0);
    chk1("rst_delay", in_delayF, 1'b0);

    // Release with a stale data_ok still on the bus: must be ignored.
    cyc();
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk1("stale_dataok_valid", validF, 1'b0);
    cyc();
    inst_data_ok = 1'b0;

    fetch(32'hBFC0_0000, 32'h2402_0001, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'hBFC0_0004, 32'h1000_003E, 3, 1, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'hBFC0_0008, 32'h2442_0001, 0, 0, 1'b1, 1'b1, 32'hBFC0_0100, 1'b1);
    fetch(32'hBFC0_0100, 32'h3C08_BFC0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Exception while waiting for data, with a simultaneous branch that must lose.
    addr_q.push_back(32'hBFC0_0104);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok  = 1'b0;
    exc_redirect  = 1'b1;
    exc_pc        = 32'hBFC0_0380;
    branch_taken  = 1'b1;
    branch_target = 32'hBFC0_0200;
    @(negedge clk);
    chk1("exc_wait_valid", validF, 1'b0);
    cyc();
    exc_redirect = 1'b0;
    branch_taken = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h8C00_0000;
    @(negedge clk);
    chk1("cancel_valid", validF, 1'b0);
    cyc();
    inst_data_ok = 1'b0;

    fetch(32'hBFC0_0380, 32'h1000_FF5F, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'hBFC0_0384, 32'h2404_0005, 0, 0, 1'b1, 1'b1, 32'hBFC0_0102, 1'b1);

    // Misaligned branch target: address error held until redirect.
    stallD = 1'b1;
    @(negedge clk);
    chk1("adel_entry_noreq", inst_req, 1'b0);
    chk1("adel_entry_valid", validF, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("adel_valid", validF, 1'b1);
      chk1("adel_flag", adelF, 1'b1);
      chk("adel_instr", instrF, 32'h0);
      chk1("adel_noreq", inst_req, 1'b0);
      chk("adel_pcplus4", pcplus4F, 32'hBFC0_0106);
      cyc();
    end
    e.instr = 32'h0;
    e.pcp4  = 32'hBFC0_0106;
    e.adel  = 1'b1;
    e.dly   = 1'b0;
    data_q.push_back(e);
    stallD       = 1'b0;
    exc_redirect = 1'b1;
    exc_pc       = 32'hBFC0_0180;
    cyc();
    exc_redirect = 1'b0;

    fetch(32'hBFC0_0180, 32'h03E0_0008, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("next_req_addr", inst_addr, 32'hBFC0_0184);
    repeat (2) cyc();
    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("data_q_drained", data_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
